// File: rtl/tick_stopwatch.sv
// Stopwatch counting MM:SS on tick_in rising edges,
// with start/pause/clear control and a scanned 7-seg display.
module tick_stopwatch #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk_in1,
  input  logic       clr_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic       running,
  output logic       rollover,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          tick_d;
  logic          rise;
  logic          inc;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic          roll_q, roll_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib;

  assign rise     = tick_in & ~tick_d;
  assign running  = (state_q == RUN);
  assign rollover = roll_q;
  assign sec_bcd  = sec_q;
  assign min_bcd  = min_q;
  assign an       = an_q;
  assign seg      = seg_q;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Control FSM next state and BCD count update
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    roll_d  = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          sec_d = 8'h00;
          min_d = 8'h00;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (start_stop) state_d = PAUSE;
        inc = rise;
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          sec_d   = 8'h00;
          min_d   = 8'h00;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (inc) begin
      if (sec_q[3:0] != 4'd9) begin
        sec_d[3:0] = sec_q[3:0] + 4'd1;
      end else begin
        sec_d[3:0] = 4'd0;
        if (sec_q[7:4] != 4'd5) begin
          sec_d[7:4] = sec_q[7:4] + 4'd1;
        end else begin
          sec_d[7:4] = 4'd0;
          if (min_q[3:0] != 4'd9) begin
            min_d[3:0] = min_q[3:0] + 4'd1;
          end else begin
            min_d[3:0] = 4'd0;
            if (min_q[7:4] != 4'd5) begin
              min_d[7:4] = min_q[7:4] + 4'd1;
            end else begin
              min_d[7:4] = 4'd0;
              roll_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  // Digit scan timing and registered segment decode of the next count
  always_comb begin
    scan_d = scan_q + SW'(1);
    dig_d  = dig_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = dig_q + 2'd1;
    end
    nib = sec_d[3:0];
    case (dig_d)
      2'd0: nib = sec_d[3:0];
      2'd1: nib = sec_d[7:4];
      2'd2: nib = min_d[3:0];
      2'd3: nib = min_d[7:4];
      default: nib = sec_d[3:0];
    endcase
    an_d  = ~(4'b0001 << dig_d);
    seg_d = dec7(nib);
  end

  // State, count and display registers with synchronous clear
  always_ff @(posedge clk_in1) begin
    if (!clr_n) begin
      state_q <= IDLE;
      tick_d  <= 1'b0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      roll_q  <= 1'b0;
      scan_q  <= '0;
      dig_q   <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      tick_d  <= tick_in;
      sec_q   <= sec_d;
      min_q   <= min_d;
      roll_q  <= roll_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: vector table, scoreboard queue,
// and hand-written rollover, pause/clear, scan and reset sequences.
module tb_tick_stopwatch;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic       running;
  logic       rollover;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [3:0] an;
  logic [6:0] seg;

  int errs = 0;
  int checks = 0;
  int m_cnt = 0;

  tick_stopwatch #(.SCAN_DIV(4)) dut (
    .clk_in1   (clk),
    .clr_n     (clr_n),
    .tick_in   (tick_in),
    .start_stop(start_stop),
    .clear     (clear),
    .running   (running),
    .rollover  (rollover),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       cl;
    logic       tk;
    logic       run;
    logic [7:0] sec;
    logic [7:0] min;
    logic       roll;
  } vec_t;

  typedef struct {
    logic       run;
    logic [7:0] sec;
    logic [7:0] min;
    logic       roll;
    string      nm;
  } exp_t;

  exp_t sb[$];
  vec_t tv[22];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.nm, ".running"}, {7'd0, running}, {7'd0, e.run});
    chk({e.nm, ".sec"}, sec_bcd, e.sec);
    chk({e.nm, ".min"}, min_bcd, e.min);
    chk({e.nm, ".roll"}, {7'd0, rollover}, {7'd0, e.roll});
  endtask

  task automatic step(input logic ss, input logic cl, input logic tk,
                      input logic run, input logic [7:0] sec,
                      input logic [7:0] min, input logic roll,
                      input string nm);
    exp_t e;
    start_stop = ss;
    clear = cl;
    tick_in = tk;
    e.run = run;
    e.sec = sec;
    e.min = min;
    e.roll = roll;
    e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    pop_check();
  endtask

  task automatic rise(input string nm);
    logic roll;
    roll = (m_cnt == 3599);
    m_cnt = (m_cnt + 1) % 3600;
    step(0, 0, 1, 1, bcd(m_cnt % 60), bcd(m_cnt / 60), roll, nm);
    step(0, 0, 0, 1, bcd(m_cnt % 60), bcd(m_cnt / 60), 1'b0,
         {nm, "_lo"});
  endtask

  logic [3:0] an_pat[4];
  logic [6:0] seg_pat[4];
  int         w;

  initial begin
    tv[0]  = '{1, 0, 0, 1, 8'h00, 8'h00, 0};
    tv[1]  = '{0, 0, 1, 1, 8'h01, 8'h00, 0};
    tv[2]  = '{0, 0, 0, 1, 8'h01, 8'h00, 0};
    tv[3]  = '{0, 0, 1, 1, 8'h02, 8'h00, 0};
    tv[4]  = '{0, 0, 1, 1, 8'h02, 8'h00, 0};
    tv[5]  = '{0, 0, 0, 1, 8'h02, 8'h00, 0};
    tv[6]  = '{0, 0, 1, 1, 8'h03, 8'h00, 0};
    tv[7]  = '{1, 0, 0, 0, 8'h03, 8'h00, 0};
    tv[8]  = '{0, 0, 1, 0, 8'h03, 8'h00, 0};
    tv[9]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0};
    tv[10] = '{1, 1, 0, 0, 8'h00, 8'h00, 0};
    tv[11] = '{1, 0, 1, 1, 8'h00, 8'h00, 0};
    tv[12] = '{0, 0, 0, 1, 8'h00, 8'h00, 0};
    tv[13] = '{0, 1, 1, 1, 8'h01, 8'h00, 0};
    tv[14] = '{1, 1, 0, 0, 8'h01, 8'h00, 0};
    tv[15] = '{1, 0, 1, 1, 8'h01, 8'h00, 0};
    tv[16] = '{0, 0, 0, 1, 8'h01, 8'h00, 0};
    tv[17] = '{1, 0, 1, 0, 8'h02, 8'h00, 0};
    tv[18] = '{0, 0, 0, 0, 8'h02, 8'h00, 0};
    tv[19] = '{0, 1, 0, 0, 8'h00, 8'h00, 0};
    tv[20] = '{0, 0, 1, 0, 8'h00, 8'h00, 0};
    tv[21] = '{0, 0, 0, 0, 8'h00, 8'h00, 0};

    an_pat  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_pat = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    clr_n = 1'b0;
    tick_in = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.running", {7'd0, running}, 8'd0);
    chk("rst.roll", {7'd0, rollover}, 8'd0);
    chk("rst.sec", sec_bcd, 8'h00);
    chk("rst.min", min_bcd, 8'h00);
    chk("rst.an", {4'd0, an}, 8'h0e);
    chk("rst.seg", {1'b0, seg}, 8'h40);
    clr_n = 1'b1;

    for (int i = 0; i < 22; i++)
      step(tv[i].ss, tv[i].cl, tv[i].tk, tv[i].run,
           tv[i].sec, tv[i].min, tv[i].roll, $sformatf("tv%0d", i));

    m_cnt = 0;
    step(1, 0, 0, 1, 8'h00, 8'h00, 0, "start");
    for (int i = 0; i < 60; i++) rise("to_1m");
    for (int i = 0; i < 3539; i++) rise("to_59m");
    rise("wrap");

    for (int i = 0; i < 5; i++) rise("to5");
    step(1, 0, 0, 0, 8'h05, 8'h00, 0, "pause5");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 8'h05, 8'h00, 0, "p_rise");
      step(0, 0, 0, 0, 8'h05, 8'h00, 0, "p_lo");
    end
    step(0, 1, 0, 0, 8'h00, 8'h00, 0, "p_clear");
    m_cnt = 0;
    step(1, 0, 0, 1, 8'h00, 8'h00, 0, "restart");
    for (int i = 0; i < 4; i++) rise("r4");
    step(0, 1, 0, 1, 8'h04, 8'h00, 0, "run_clear");
    m_cnt = 4;

    for (int i = 0; i < 750; i++) rise("to1234");
    step(1, 0, 0, 0, 8'h34, 8'h12, 0, "pause1234");
    w = 0;
    while (an !== 4'b0111 && w < 20) begin
      @(negedge clk);
      w++;
    end
    while (an !== 4'b1110 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("scan_sync", {7'd0, (w < 20)}, 8'd1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("scan_an%0d", k), {4'd0, an}, {4'd0, an_pat[(k/4)%4]});
      chk($sformatf("scan_seg%0d", k), {1'b0, seg},
          {1'b0, seg_pat[(k/4)%4]});
      @(negedge clk);
    end

    step(0, 1, 0, 0, 8'h00, 8'h00, 0, "clr1234");
    m_cnt = 0;
    step(1, 0, 0, 1, 8'h00, 8'h00, 0, "start742");
    for (int i = 0; i < 462; i++) rise("to742");
    chk("pre_rst.sec", sec_bcd, 8'h42);
    chk("pre_rst.min", min_bcd, 8'h07);
    clr_n = 1'b0;
    tick_in = 1'b1;
    @(negedge clk);
    chk("mrst.running", {7'd0, running}, 8'd0);
    chk("mrst.sec", sec_bcd, 8'h00);
    chk("mrst.min", min_bcd, 8'h00);
    chk("mrst.an", {4'd0, an}, 8'h0e);
    chk("mrst.seg", {1'b0, seg}, 8'h40);
    clr_n = 1'b1;
    step(0, 0, 1, 0, 8'h00, 8'h00, 0, "post_rst_rise");
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, "post_rst_lo");
    step(0, 0, 1, 0, 8'h00, 8'h00, 0, "idle_rise");

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tick_stopwatch.md
TICK_STOPWATCH -- requirements
Module: tick_stopwatch

Interface
REQ-001 SCAN_DIV, 50000, number of clk_in1 cycles each display digit is driven; legal range 2..65535.
REQ-002 clk_in1  input  1  system clock; all logic on rising edge.
REQ-003 clr_n  input  1  reset, synchronous, active-low.
REQ-004 tick_in  input  1  square wave from the upstream divider, synchronous to clk_in1; each rising edge = one time unit.
REQ-005 start_stop  input  1  single-cycle command pulse: start/pause toggle.
REQ-006 clear  input  1  single-cycle command pulse: zero the count.
REQ-007 running  output  1  high while state is RUN.
REQ-008 rollover  output  1  one-cycle pulse when count wraps 59:59 -> 00:00.
REQ-009 sec_bcd  output  8  seconds, two BCD digits, 00..59.
REQ-010 min_bcd  output  8  minutes, two BCD digits, 00..59.
REQ-011 an  output  4  digit enables, active-low; an[0]=sec ones, an[1]=sec tens, an[2]=min ones, an[3]=min tens.
REQ-012 seg  output  7  segment drive, active-low; seg[0]=a .. seg[6]=g.

Function
REQ-013 The block SHALL register tick_in into tick_d and SHALL define rise = tick_in & ~tick_d.
REQ-014 State machine SHALL have states IDLE, RUN, PAUSE.
REQ-015 start_stop SHALL move IDLE->RUN, RUN->PAUSE, PAUSE->RUN on the next clock edge.
REQ-016 clear SHALL, in IDLE or PAUSE, zero sec_bcd and min_bcd and enter IDLE on the next edge.
REQ-017 clear SHALL be ignored in RUN.
REQ-018 clear asserted together with start_stop SHALL take priority; start_stop is then ignored, except in RUN, where clear is ignored and start_stop acts.
REQ-019 In RUN, each rise SHALL increment the count on the same clock edge at which rise is true, i.e. the new value is visible one cycle after tick_in is first sampled high.
REQ-020 In IDLE and PAUSE, rise SHALL be ignored; the count holds.
REQ-021 A rise coinciding with a start_stop that leaves RUN SHALL still be counted; a rise coinciding with a start_stop that enters RUN SHALL NOT be counted.
REQ-022 Sec ones SHALL count 0..9, sec tens 0..5, min ones 0..9, min tens 0..5, each carrying into the next digit.
REQ-023 At 59:59 a rise SHALL produce 00:00 and assert rollover for exactly that one cycle; rollover SHALL otherwise be 0.
REQ-024 The scan counter SHALL count 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and the digit index SHALL advance 0->1->2->3->0.
REQ-025 an SHALL drive exactly one bit low: bit [digit index]. seg SHALL be the registered active-low decode of that digit's BCD value, updated on the same edge as an.
REQ-026 Decode (seg[6:0], g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-027 BCD values outside 0..9 SHALL never occur; if decoded, seg SHALL be 1111111 (blank).
REQ-028 Display scanning SHALL continue in every state, including IDLE.

Reset
REQ-029 clr_n low at a rising edge SHALL, on that edge, set state IDLE, sec_bcd=8'h00, min_bcd=8'h00, running=0, rollover=0, tick_d=0, scan counter=0, digit index=0, an=4'b1110, seg=7'b1000000.
REQ-030 Reset SHALL override all inputs, including a rise or a command pulse in the same cycle, and SHALL take effect mid-count from any state.
REQ-031 After clr_n returns high, the first rise SHALL NOT be counted because the state is IDLE.

Verification
REQ-032 Reset; pulse start_stop; apply 3 tick_in rising edges -> running=1, sec_bcd=8'h03, min_bcd=8'h00.
REQ-033 Preload to 00:59 in RUN; one rise -> sec_bcd=8'h00 and min_bcd=8'h01 one cycle after tick_in is sampled high; rollover stays 0.
REQ-034 Reach 59:59 in RUN; one rise -> 00:00 and rollover high for exactly 1 cycle.
REQ-035 In RUN at 00:05, pulse start_stop then apply 4 rises -> PAUSE, count holds 00:05; pulse clear -> IDLE, 00:00; in RUN, pulse clear -> no effect.
REQ-036 SCAN_DIV=4 at count 12:34 -> an cycles 1110, 1101, 1011, 0111 every 4 cycles, with seg = 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
REQ-037 clr_n low for one cycle in RUN at 07:42, coinciding with a rise -> next cycle 00:00, IDLE, an=1110, seg=1000000.
